// File: rtl/ip_field_extract.sv
// Streaming Ethernet/IPv4 header field extractor with saturating packet statistics.
// Consumes 32-bit big-endian beats; emits a one-cycle-strobed field record per good packet.
module ip_field_extract #(
    parameter int unsigned CNT_W          = 16,
    parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic [31:0]      in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [1:0]       in_empty,
    input  logic             in_valid,
    output logic             f_valid,
    output logic [7:0]       f_tos,
    output logic [15:0]      f_len,
    output logic [15:0]      f_ident,
    output logic [2:0]       f_flags,
    output logic [12:0]      f_frag_off,
    output logic [7:0]       f_ttl,
    output logic [7:0]       f_proto,
    output logic [15:0]      f_csum,
    output logic [31:0]      f_src_ip,
    output logic [31:0]      f_dst_ip,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] non_ip_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHdr  = 2'd1;
    localparam logic [1:0] StBody = 2'd2;
    localparam logic [1:0] StSkip = 2'd3;

    typedef struct packed {
        logic [7:0]  tos;
        logic [15:0] len;
        logic [15:0] ident;
        logic [2:0]  flags;
        logic [12:0] frag_off;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] csum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } rec_t;

    logic [1:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    rec_t             sh_q, sh_d;
    rec_t             f_q, f_d;
    logic             fv_q, fv_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0] non_q, non_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             inc_pkt, inc_non, inc_err;
    logic             not_ipv4;
    logic [3:0]       idx_inc;

    // Frame trailer byte count is irrelevant to header parsing.
    logic unused_empty;
    assign unused_empty = ^in_empty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    assign not_ipv4 = (in_data[31:16] != ETHERTYPE_IPV4) || (in_data[15:12] != 4'd4);
    assign idx_inc  = (idx_q == 4'd15) ? 4'd15 : idx_q + 4'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        f_d     = f_q;
        fv_d    = 1'b0;
        inc_pkt = 1'b0;
        inc_non = 1'b0;
        inc_err = 1'b0;

        if (in_valid) begin
            if (in_sop) begin
                // Either an abort of an open packet or a one-beat runt; one error either way.
                inc_err = (state_q != StIdle) || in_eop;
                state_d = in_eop ? StIdle : StHdr;
                idx_d   = in_eop ? 4'd0 : 4'd1;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StHdr: begin
                        case (idx_q)
                            4'd3: sh_d.tos = in_data[7:0];
                            4'd4: begin
                                sh_d.len   = in_data[31:16];
                                sh_d.ident = in_data[15:0];
                            end
                            4'd5: begin
                                sh_d.flags    = in_data[31:29];
                                sh_d.frag_off = in_data[28:16];
                                sh_d.ttl      = in_data[15:8];
                                sh_d.proto    = in_data[7:0];
                            end
                            4'd6: begin
                                sh_d.csum          = in_data[31:16];
                                sh_d.src_ip[31:16] = in_data[15:0];
                            end
                            4'd7: begin
                                sh_d.src_ip[15:0]  = in_data[31:16];
                                sh_d.dst_ip[31:16] = in_data[15:0];
                            end
                            4'd8: sh_d.dst_ip[15:0] = in_data[31:16];
                            default: ;
                        endcase
                        idx_d = idx_inc;
                        if (in_eop) begin
                            // eop on w8 completes the header; anything earlier is a runt.
                            if (idx_q == 4'd8) begin
                                f_d     = sh_d;
                                fv_d    = 1'b1;
                                inc_pkt = 1'b1;
                            end else begin
                                inc_err = 1'b1;
                            end
                            state_d = StIdle;
                            idx_d   = 4'd0;
                        end else if (idx_q == 4'd3 && not_ipv4) begin
                            state_d = StSkip;
                        end else if (idx_q == 4'd8) begin
                            state_d = StBody;
                        end
                    end
                    StBody: begin
                        idx_d = idx_inc;
                        if (in_eop) begin
                            f_d     = sh_q;
                            fv_d    = 1'b1;
                            inc_pkt = 1'b1;
                            state_d = StIdle;
                            idx_d   = 4'd0;
                        end
                    end
                    StSkip: begin
                        idx_d = idx_inc;
                        if (in_eop) begin
                            inc_non = 1'b1;
                            state_d = StIdle;
                            idx_d   = 4'd0;
                        end
                    end
                endcase
            end
        end

        pkt_d = sat_inc(pkt_q, inc_pkt);
        non_d = sat_inc(non_q, inc_non);
        err_d = sat_inc(err_q, inc_err);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            sh_q    <= '0;
            f_q     <= '0;
            fv_q    <= 1'b0;
            pkt_q   <= '0;
            non_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            f_q     <= f_d;
            fv_q    <= fv_d;
            pkt_q   <= pkt_d;
            non_q   <= non_d;
            err_q   <= err_d;
        end
    end

    assign f_valid      = fv_q;
    assign f_tos        = f_q.tos;
    assign f_len        = f_q.len;
    assign f_ident      = f_q.ident;
    assign f_flags      = f_q.flags;
    assign f_frag_off   = f_q.frag_off;
    assign f_ttl        = f_q.ttl;
    assign f_proto      = f_q.proto;
    assign f_csum       = f_q.csum;
    assign f_src_ip     = f_q.src_ip;
    assign f_dst_ip     = f_q.dst_ip;
    assign pkt_count    = pkt_q;
    assign non_ip_count = non_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_ip_field_extract.sv
// Scoreboard bench for ip_field_extract: packet-level reference model, directed then random traffic.
module tb_ip_field_extract;

    localparam int unsigned CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             sys_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
    logic [1:0]       in_empty = '0;
    logic             f_valid;
    logic [7:0]       f_tos, f_ttl, f_proto;
    logic [15:0]      f_len, f_ident, f_csum;
    logic [2:0]       f_flags;
    logic [12:0]      f_frag_off;
    logic [31:0]      f_src_ip, f_dst_ip;
    logic [CNT_W-1:0] pkt_count, non_ip_count, err_count;

    ip_field_extract #(.CNT_W(CNT_W), .ETHERTYPE_IPV4(16'h0800)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .in_valid(in_valid),
        .f_valid(f_valid), .f_tos(f_tos), .f_len(f_len), .f_ident(f_ident),
        .f_flags(f_flags), .f_frag_off(f_frag_off), .f_ttl(f_ttl), .f_proto(f_proto),
        .f_csum(f_csum), .f_src_ip(f_src_ip), .f_dst_ip(f_dst_ip),
        .pkt_count(pkt_count), .non_ip_count(non_ip_count), .err_count(err_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [151:0] rec;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           errors = 0;
    int           checks = 0;
    int           ncyc = 0;
    int           m_pkt = 0, m_non = 0, m_err = 0;
    logic [151:0] m_last = '0;
    logic [31:0]  pw [16];
    logic [151:0] dut_rec;

    assign dut_rec = {f_tos, f_len, f_ident, f_flags, f_frag_off, f_ttl, f_proto, f_csum,
                      f_src_ip, f_dst_ip};

    // Header fields are laid out contiguously from the TOS byte of w3 through the top half of w8.
    function automatic logic [151:0] rec_of(input logic [31:0] w3, input logic [31:0] w4,
                                            input logic [31:0] w5, input logic [31:0] w6,
                                            input logic [31:0] w7, input logic [31:0] w8);
        return {w3[7:0], w4, w5, w6, w7, w8[31:16]};
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every f_valid must match the oldest expected record in the expected cycle.
    always @(negedge sys_clk) begin
        ncyc++;
        if (f_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_f_valid: got record %0h expected none", dut_rec);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (dut_rec !== e.rec || ncyc != e.cyc) begin
                    errors++;
                    $display("FAIL record: got %0h at cycle %0d expected %0h at cycle %0d",
                             dut_rec, ncyc, e.rec, e.cyc);
                end
            end
        end else if (sbq.size() > 0 && sbq[0].cyc < ncyc) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_f_valid: got none expected %0h at cycle %0d", e.rec, e.cyc);
        end
    end

    task automatic drive(input bit v, input bit s, input bit e, input logic [31:0] d,
                         output int c);
        @(posedge sys_clk);
        #1;
        in_valid = v;
        in_sop   = s;
        in_eop   = e;
        in_data  = d;
        in_empty = 2'($urandom);
        c = ncyc + 2;
    endtask

    task automatic idle(input int n);
        int c;
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom), $urandom, c);
    endtask

    task automatic send_pkt(input int n, input bit term, input int gap_at, input int gap_pct);
        int  c;
        int  last;
        bit  ipv4;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                if (i == gap_at) idle(3);
                else if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
            end
            drive(1'b1, i == 0, term && (i == n - 1), pw[i], c);
        end
        if (!term) begin
            m_err = sat(m_err);
        end else begin
            last = n - 1;
            ipv4 = (pw[3][31:16] == 16'h0800) && (pw[3][15:12] == 4'd4);
            if (last <= 3) m_err = sat(m_err);
            else if (!ipv4) m_non = sat(m_non);
            else if (last < 8) m_err = sat(m_err);
            else begin
                exp_t e;
                e.rec = rec_of(pw[3], pw[4], pw[5], pw[6], pw[7], pw[8]);
                e.cyc = c;
                sbq.push_back(e);
                m_pkt  = sat(m_pkt);
                m_last = e.rec;
            end
        end
    endtask

    task automatic check_state(input string tag);
        idle(3);
        chk({tag, "_pkt_count"}, 152'(pkt_count), 152'(m_pkt));
        chk({tag, "_non_ip_count"}, 152'(non_ip_count), 152'(m_non));
        chk({tag, "_err_count"}, 152'(err_count), 152'(m_err));
        chk({tag, "_held_record"}, dut_rec, m_last);
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_record", dut_rec, '0);
        chk("rst_f_valid", 152'(f_valid), '0);
        chk("rst_counts", 152'({pkt_count, non_ip_count, err_count}), '0);
        sbq.delete();
        m_pkt = 0; m_non = 0; m_err = 0; m_last = '0;
        repeat (2) @(posedge sys_clk);
        #3 reset_n = 1'b1;
    endtask

    task automatic fill_plan();
        for (int i = 0; i < 16; i++) pw[i] = $urandom;
        pw[3] = 32'h08004500; pw[4] = 32'h00541234; pw[5] = 32'h40004011;
        pw[6] = 32'hBEEFC0A8; pw[7] = 32'h0001C0A8; pw[8] = 32'h00020000;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) pw[i] = $urandom;
        if ($urandom_range(0, 99) < 75) pw[3][31:12] = 20'h08004;
    endtask

    initial begin
        int c;
        int n;
        do_reset();

        fill_plan();
        send_pkt(12, 1'b1, -1, 0);
        check_state("single");
        chk("plan_len_ident", 152'({f_len, f_ident}), 152'(32'h00541234));
        chk("plan_flags_ttl_proto", 152'({f_flags, f_frag_off, f_ttl, f_proto}),
            152'({3'b010, 13'd0, 8'h40, 8'h11}));
        chk("plan_addrs", 152'({f_csum, f_src_ip, f_dst_ip}),
            152'({16'hBEEF, 32'hC0A80001, 32'hC0A80002}));

        fill_plan();
        send_pkt(12, 1'b1, 5, 0);
        check_state("gap");

        fill_plan();
        pw[3] = 32'h08060001;
        send_pkt(10, 1'b1, -1, 0);
        check_state("arp");

        fill_plan();
        send_pkt(5, 1'b1, -1, 0);
        send_pkt(1, 1'b1, -1, 0);
        check_state("short");

        fill_plan();
        send_pkt(7, 1'b0, -1, 0);
        fill_random();
        pw[3][31:12] = 20'h08004;
        send_pkt(11, 1'b1, -1, 0);
        check_state("abort");

        fill_plan();
        send_pkt(6, 1'b0, -1, 0);
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'($urandom), $urandom, c);
        check_state("post_reset_ignore");
        fill_plan();
        send_pkt(12, 1'b1, -1, 20);
        check_state("post_reset_pkt");

        for (int k = 0; k < 17; k++) begin
            fill_random();
            pw[3][31:12] = 20'h08004;
            send_pkt($urandom_range(9, 14), 1'b1, -1, 10);
        end
        check_state("saturate");

        do_reset();
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 99) < 15) begin
                fill_random();
                send_pkt($urandom_range(1, 12), 1'b0, -1, 20);
                n = $urandom_range(5, 14);
            end else begin
                if ($urandom_range(0, 99) < 30) begin
                    for (int i = 0; i < 2; i++)
                        drive(1'b1, 1'b0, 1'($urandom), $urandom, c);
                end
                n = $urandom_range(1, 14);
                if (n == 4) n = 5;
            end
            fill_random();
            send_pkt(n, 1'b1, -1, 20);
            if (k % 6 == 5) check_state("random");
        end
        check_state("random_end");

        idle(5);
        chk("scoreboard_drained", 152'(sbq.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ip_field_extract.md
Name: ip_field_extract

Overview:
- Streaming header parser on the ingress avln_st path, directly upstream of seaccow_internal's analysis logic.
- Consumes Ethernet/IPv4 frames as 32-bit big-endian beats.
- Emits a one-cycle-strobed record of IPv4 header fields per accepted packet; keeps saturating counters for good, non-IP and malformed packets.
- No backpressure: every valid beat is consumed.

Parameters:
- CNT_W, 16, width of each saturating statistics counter.
- ETHERTYPE_IPV4, 16'h0800, ethertype accepted as IPv4.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in  in  avln_st  ingress stream: data[31:0], sop, eop, empty[1:0], valid; empty ignored.
- f_valid  out  1  one-cycle strobe: new field record on f_* outputs.
- f_tos  out  8  IPv4 TOS byte.
- f_len  out  16  IPv4 total length.
- f_ident  out  16  IPv4 identification.
- f_flags  out  3  IPv4 flags.
- f_frag_off  out  13  fragment offset.
- f_ttl  out  8  time to live.
- f_proto  out  8  protocol.
- f_csum  out  16  header checksum.
- f_src_ip  out  32  source address.
- f_dst_ip  out  32  destination address.
- pkt_count  out  CNT_W  IPv4 records emitted, saturating.
- non_ip_count  out  CNT_W  complete packets with other ethertype or IP version != 4, saturating.
- err_count  out  CNT_W  short or aborted packets, saturating.

Behaviour:
- Reset (asynchronous, reset_n low): all outputs 0, state IDLE, word counter 0, shadow field registers 0.
- A beat is consumed only when in.valid=1. Beats with valid=0 change no state.
- Word index: sop beat = word 0; index increments per consumed beat; saturates at 15.
- Field map by word index:
  - w3: ethertype = [31:16]; version = [15:12]; tos = [7:0].
  - w4: len = [31:16]; ident = [15:0].
  - w5: flags = [31:29]; frag_off = [28:16]; ttl = [15:8]; proto = [7:0].
  - w6: csum = [31:16]; src_ip[31:16] = [15:0].
  - w7: src_ip[15:0] = [31:16]; dst_ip[31:16] = [15:0].
  - w8: dst_ip[15:0] = [31:16].
  - Fields are captured into shadow registers. IHL > 5 options and payload are ignored.
- States and transitions:
  - IDLE: wait for valid & sop; go to HDR at index 1. Non-sop valid beats in IDLE are ignored, with no counter change.
  - HDR: capture fields. On w3, if ethertype != ETHERTYPE_IPV4 or version != 4, go to SKIP. After w8, go to BODY.
  - BODY: wait for eop.
  - SKIP: wait for eop.
- End of packet (eop beat, including eop on w8):
  - In BODY: copy shadows to f_*; f_valid=1 on the next cycle for exactly one cycle; pkt_count++.
  - In SKIP: non_ip_count++; no record.
  - In HDR before w8 (short packet, including single-beat sop+eop): err_count++; no record; f_* unchanged.
  - All cases then go to IDLE.
- Abort: sop while in HDR/BODY/SKIP means the previous packet is aborted.
  - err_count++.
  - The new sop beat is taken as word 0 of a new packet, so the state returns to HDR at index 1.
  - No record is emitted for the aborted packet.
- f_* hold their last record until the next f_valid.
- f_valid latency: asserted in the cycle after the eop beat is sampled.
- Counters saturate at 2^CNT_W-1 and never wrap. At most one counter increments per cycle.

Test Plan:
- Single IPv4 packet of 12 beats; w3=0x08004500, w4=0x00541234, w5=0x40004011, w6=0xBEEFC0A8, w7=0x0001C0A8, w8=0x00020000 -> one f_valid one cycle after eop; f_tos=00, f_len=0x0054, f_ident=0x1234, f_flags=3'b010, f_frag_off=0, f_ttl=0x40, f_proto=0x11, f_csum=0xBEEF, f_src_ip=C0A80001, f_dst_ip=C0A80002; pkt_count=1.
- Same packet with valid deasserted for 3 cycles between w4 and w5 -> identical record; f_valid one cycle after eop.
- ARP packet (w3=0x08060001), 10 beats -> no f_valid; non_ip_count=1; f_* keep previous values.
- 5-beat packet with eop on w4, then sop+eop single beat -> no f_valid; err_count=2.
- sop reasserted at w6 of packet A, then full valid packet B -> err_count=1; exactly one f_valid carrying B's fields; pkt_count=1.
- reset_n pulsed low mid-packet at w5, then valid packet -> all outputs 0 during reset; beats before the next sop ignored; the next packet yields a correct record with pkt_count=1.
- CNT_W=4 with 17 good packets -> pkt_count=15, saturated.
